pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- RESET_PC, 32'h0000_0000, program_counter value loaded on reset.
- PC_STEP, 32'h0000_0001, sequential increment; program_counter is a word index into instruction memory.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding treated as halt (used only under REQ-024).

REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clock, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-low reset.
- stall, in, 1, hold program_counter and IF/ID outputs.
- branch_taken, in, 1, redirect to branch_target.
- branch_target, in, 32, word-index branch destination.
- jump, in, 1, redirect to jump target.
- jump_target, in, 26, J-format index field.
- instruction, in, 32, combinational instruction-memory data for the current program_counter.
- program_counter, out, 32, word index driven to instruction memory.
- if_id_instruction, out, 32, captured instruction.
- if_id_pc_next, out, 32, program_counter+PC_STEP of the captured instruction.
- if_id_valid, out, 1, IF/ID holds a real instruction.
- fetch_count, out, 32, count of valid captures.
- halted, out, 1, fetch stopped.

Function
REQ-003 Instruction memory SHALL be treated as combinational: instruction corresponds to program_counter in the same cycle, so fetch latency is one clock from PC to IF/ID.
REQ-004 The FSM SHALL have states BOOT, RUN and HALTED.
REQ-005 BOOT is entered on reset. It SHALL last exactly one cycle, with if_id_valid=0 and program_counter=RESET_PC, then go to RUN.
REQ-006 In RUN, per edge, the priority SHALL be: stall > branch_taken > jump > sequential.
REQ-007 Stall SHALL hold program_counter, if_id_instruction, if_id_pc_next, if_id_valid and fetch_count unchanged. Redirect inputs asserted during stall SHALL be ignored (the producer holds them).
REQ-008 Sequential fetch: program_counter SHALL become program_counter+PC_STEP, IF/ID SHALL capture instruction and program_counter+PC_STEP, if_id_valid SHALL be 1, and fetch_count SHALL increment.
REQ-009 Branch: program_counter SHALL become branch_target, if_id_valid SHALL be 0 (the wrong-path instruction is squashed), and fetch_count SHALL NOT increment.
REQ-010 Jump: program_counter SHALL become {pc_next[31:26], jump_target}, where pc_next = program_counter+PC_STEP. Squash SHALL be the same as for a branch.
REQ-011 If branch_taken and jump are asserted together, the branch SHALL win and the jump SHALL be dropped.
REQ-012 program_counter and fetch_count arithmetic SHALL be modulo 2^32 (0xFFFF_FFFF + 1 wraps to 0), with no error flag.
REQ-013 When if_id_valid=0, if_id_instruction SHALL read 32'h0000_0000 (NOP).
REQ-014 halted SHALL be 1 only in HALTED.

Reset
REQ-015 Reset SHALL be sampled only on the rising edge of clock while reset=0. Asynchronous reset behaviour is forbidden.
REQ-016 Reset values SHALL be:
- program_counter=RESET_PC
- if_id_instruction=0
- if_id_pc_next=0
- if_id_valid=0
- fetch_count=0
- halted=0
- state=BOOT
REQ-017 Reset SHALL override stall, redirects and HALTED.
REQ-018 Reset asserted mid-stream SHALL discard the in-flight IF/ID contents in the same edge.
REQ-019 After reset is released, the first valid IF/ID capture SHALL occur on the second rising edge (BOOT, then RUN).

Configuration
REQ-020 Macro PC_FETCH_HALT_DETECT_EN SHALL control halt detection.
REQ-021 With PC_FETCH_HALT_DETECT_EN defined: in RUN with no stall and no redirect, instruction==HALT_WORD SHALL move the FSM to HALTED on that edge.
REQ-022 On that edge, the halt word SHALL be captured with if_id_valid=1 and counted, and program_counter SHALL NOT advance.
REQ-023 In HALTED, program_counter SHALL be frozen, if_id_valid=0, all inputs except reset SHALL be ignored, and HALTED SHALL exit only via reset.
REQ-024 Without PC_FETCH_HALT_DETECT_EN: HALTED SHALL be unreachable, halted SHALL be tied to 0, HALT_WORD SHALL be treated as an ordinary instruction, and the halt logic SHALL be absent from synthesis.

Verification
REQ-025 Reset/boot: hold reset=0 for 3 edges, then release with instruction memory words 0..2 = A,B,C -> program_counter=0 and valid=0 for one cycle; then IF/ID = A, B, C on consecutive edges; fetch_count=3.
REQ-026 Branch squash: at program_counter=5, assert branch_taken with branch_target=0x20 for one edge -> program_counter=0x20, if_id_valid=0; the next edge captures word 0x20.
REQ-027 Priority: at program_counter=4, assert branch_taken (target 0x10), jump (target 0x3) and stall together for 2 edges -> nothing changes. Then drop stall -> program_counter=0x10.
REQ-028 Wrap: force program_counter to 0xFFFF_FFFF via branch, run one sequential edge -> program_counter=0, if_id_pc_next=0.
REQ-029 Halt (macro defined): word 2 = 0xFFFF_FFFF -> halted=1 after capturing it, program_counter stays 2, fetch_count=3. Pulsing reset restores program_counter=0 and halted=0. With the macro undefined, the fetch continues to program_counter=3.
REQ-030 Mid-stream reset: assert reset=0 for one edge while if_id_valid=1 at program_counter=7 -> all outputs equal the REQ-016 values on that edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: BOOT/RUN/HALTED program-counter sequencer feeding an IF/ID register.
// Halt detection is compiled in only when PC_FETCH_HALT_DETECT_EN is defined.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'h0000_0001,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic [31:0] instruction,
    output logic [31:0] program_counter,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_next,
    output logic        if_id_valid,
    output logic [31:0] fetch_count,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_r,       state_nxt_s;
    logic [31:0] pc_r,          pc_nxt_s;
    logic [31:0] instr_r,       instr_nxt_s;
    logic [31:0] pc_next_r,     pc_next_nxt_s;
    logic        valid_r,       valid_nxt_s;
    logic [31:0] count_r,       count_nxt_s;
    logic [31:0] pc_inc_s;
`ifdef PC_FETCH_HALT_DETECT_EN
    logic        halted_r,      halted_nxt_s;
`endif

    assign pc_inc_s = pc_r + PC_STEP;

    // Next-state and next-output selection; every path starts from "hold".
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        instr_nxt_s   = instr_r;
        pc_next_nxt_s = pc_next_r;
        valid_nxt_s   = valid_r;
        count_nxt_s   = count_r;
`ifdef PC_FETCH_HALT_DETECT_EN
        halted_nxt_s  = halted_r;
`endif
        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_RUN;
                valid_nxt_s = 1'b0;
                instr_nxt_s = 32'h0000_0000;
            end
            ST_RUN: begin
                if (stall) begin
                    state_nxt_s = ST_RUN;
                end else if (branch_taken) begin
                    pc_nxt_s    = branch_target;
                    valid_nxt_s = 1'b0;
                    instr_nxt_s = 32'h0000_0000;
                end else if (jump) begin
                    pc_nxt_s    = {pc_inc_s[31:26], jump_target};
                    valid_nxt_s = 1'b0;
                    instr_nxt_s = 32'h0000_0000;
                end else begin
                    instr_nxt_s   = instruction;
                    pc_next_nxt_s = pc_inc_s;
                    valid_nxt_s   = 1'b1;
                    count_nxt_s   = count_r + 32'd1;
`ifdef PC_FETCH_HALT_DETECT_EN
                    // The halt word is still captured and counted, but the PC parks on it.
                    if (instruction == HALT_WORD) begin
                        state_nxt_s  = ST_HALTED;
                        halted_nxt_s = 1'b1;
                    end else begin
                        pc_nxt_s = pc_inc_s;
                    end
`else
                    pc_nxt_s = pc_inc_s;
`endif
                end
            end
`ifdef PC_FETCH_HALT_DETECT_EN
            ST_HALTED: begin
                state_nxt_s = ST_HALTED;
                valid_nxt_s = 1'b0;
                instr_nxt_s = 32'h0000_0000;
            end
`endif
            default: begin
                state_nxt_s = ST_BOOT;
                valid_nxt_s = 1'b0;
                instr_nxt_s = 32'h0000_0000;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= ST_BOOT;
            pc_r      <= RESET_PC;
            instr_r   <= 32'h0000_0000;
            pc_next_r <= 32'h0000_0000;
            valid_r   <= 1'b0;
            count_r   <= 32'h0000_0000;
`ifdef PC_FETCH_HALT_DETECT_EN
            halted_r  <= 1'b0;
`endif
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            instr_r   <= instr_nxt_s;
            pc_next_r <= pc_next_nxt_s;
            valid_r   <= valid_nxt_s;
            count_r   <= count_nxt_s;
`ifdef PC_FETCH_HALT_DETECT_EN
            halted_r  <= halted_nxt_s;
`endif
        end
    end

    assign program_counter   = pc_r;
    assign if_id_instruction = instr_r;
    assign if_id_pc_next     = pc_next_r;
    assign if_id_valid       = valid_r;
    assign fetch_count       = count_r;
`ifdef PC_FETCH_HALT_DETECT_EN
    assign halted            = halted_r;
`else
    assign halted            = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a reference model predicts each edge, a monitor compares after it.
module tb_pc_fetch_unit;

    logic        clock = 1'b0;
    logic        reset, stall, branch_taken, jump;
    logic [31:0] branch_target;
    logic [25:0] jump_target;
    logic [31:0] instruction;
    logic [31:0] program_counter, if_id_instruction, if_id_pc_next, fetch_count;
    logic        if_id_valid, halted;
    logic        halt_on = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    pc_fetch_unit dut (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .instruction(instruction),
        .program_counter(program_counter), .if_id_instruction(if_id_instruction),
        .if_id_pc_next(if_id_pc_next), .if_id_valid(if_id_valid),
        .fetch_count(fetch_count), .halted(halted)
    );

    always #5 clock = ~clock;

    // Instruction memory contents: never all-ones, except the planted halt word at address 2.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic hon);
        if (hon && a == 32'd2) return 32'hFFFF_FFFF;
        return ((a * 32'h9E37_79B1) + 32'h0000_1357) & 32'h7FFF_FFFF;
    endfunction

    assign instruction = mem_word(program_counter, halt_on);

    typedef struct {
        logic [31:0] pc, instr, pnext, cnt;
        logic        valid, hlt, chk_pnext;
        string       tag;
    } exp_t;
    exp_t sb[$];

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc, m_instr, m_pnext, m_cnt;
    logic        m_valid, m_hlt, m_booting, m_pnext_known;

`ifdef PC_FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    task automatic model_step(input logic rst, st, br, input logic [31:0] bt,
                              input logic jp, input logic [25:0] jt);
        logic [31:0] w, nxt;
        if (!rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pnext = 32'h0; m_cnt = 32'h0;
            m_valid = 1'b0; m_hlt = 1'b0; m_booting = 1'b1; m_pnext_known = 1'b1;
        end else if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_hlt) begin
            m_valid = 1'b0; m_instr = 32'h0;
        end else if (st) begin
            m_valid = m_valid;
        end else if (br || jp) begin
            nxt     = m_pc + 32'd1;
            m_pc    = br ? bt : {nxt[31:26], jt};
            m_valid = 1'b0; m_instr = 32'h0; m_pnext_known = 1'b0;
        end else begin
            w   = mem_word(m_pc, halt_on);
            nxt = m_pc + 32'd1;
            m_instr = w; m_pnext = nxt; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
            m_pnext_known = 1'b1;
            if (HALT_EN && w == 32'hFFFF_FFFF) m_hlt = 1'b1;
            else m_pc = nxt;
        end
    endtask

    task automatic drive(input logic rst, st, br, input logic [31:0] bt,
                         input logic jp, input logic [25:0] jt, input string tag);
        exp_t e;
        @(negedge clock);
        reset = rst; stall = st; branch_taken = br; branch_target = bt;
        jump = jp; jump_target = jt;
        model_step(rst, st, br, bt, jp, jt);
        e.pc = m_pc; e.instr = m_instr; e.pnext = m_pnext; e.cnt = m_cnt;
        e.valid = m_valid; e.hlt = m_hlt; e.chk_pnext = m_pnext_known; e.tag = tag;
        sb.push_back(e);
        @(posedge clock);
    endtask

    task automatic seq(input string tag);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, tag);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: every edge presents new outputs; pop the prediction and compare.
    always @(posedge clock) begin
        #1;
        cyc++;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ".pc"},    program_counter,   e.pc);
            chk({e.tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, e.valid});
            chk({e.tag, ".instr"}, if_id_instruction, e.instr);
            chk({e.tag, ".count"}, fetch_count,       e.cnt);
            chk({e.tag, ".halted"}, {31'h0, halted},  {31'h0, e.hlt});
            if (e.chk_pnext) chk({e.tag, ".pc_next"}, if_id_pc_next, e.pnext);
        end
    end

    task automatic run_to_pc(input logic [31:0] target, input string tag);
        for (int i = 0; i < 64; i++) begin
            if (m_pc == target && m_valid && !m_booting) return;
            seq(tag);
        end
        tests++; fails++;
        $display("FAIL %s reach_pc actual=%h expected=%h", tag, m_pc, target);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_target = 26'h0;
        m_booting = 1'b1;

        // Reset for three edges, then boot and three sequential captures.
        repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, "reset");
        seq("boot");
        repeat (3) seq("seq");

        // Branch squash at pc 5.
        run_to_pc(32'd5, "to5");
        drive(1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 26'h0, "branch");
        seq("after_branch");

        // Priority: stall over branch over jump.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, "reset2");
        seq("boot2");
        run_to_pc(32'd4, "to4");
        repeat (2) drive(1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 26'h3, "stall_all");
        drive(1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 26'h3, "br_vs_jump");
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 26'h3FF_FFFF, "jump");

        // Wrap of the program counter.
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 26'h0, "to_max");
        seq("wrap");
        seq("after_wrap");

        // Halt word at address 2.
        halt_on = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, "reset3");
        seq("boot3");
        repeat (3) seq("to_halt");
        drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 26'h0, "halt_br");
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 26'h5, "halt_jp");
        seq("halt_seq");
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, "halt_reset");
        halt_on = 1'b0;
        seq("boot4");

        // Mid-stream reset at pc 7 with a valid instruction in IF/ID.
        run_to_pc(32'd7, "to7");
        drive(1'b0, 1'b1, 1'b1, 32'h99, 1'b1, 26'h9, "mid_reset");
        seq("boot5");

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            logic        r, s, b, j;
            logic [31:0] bt;
            r  = ($urandom_range(0, 59) != 0);
            s  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 5) == 0);
            j  = ($urandom_range(0, 5) == 0);
            bt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2))) : $urandom;
            drive(r, s, b, bt, j, 26'($urandom), "rand");
        end

        @(negedge clock);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain actual=%0d expected=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
